// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer.
// State codes, opcodes, datapath select encodings and the control bundle.
package multicycle_control_pkg;

   localparam int OP_WIDTH = 6;
   localparam int ST_WIDTH = 4;

   typedef enum logic [ST_WIDTH-1:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMRD    = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWR    = 4'd6,
      S_EXEC     = 4'd7,
      S_RTYPE_WB = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_ADDI_EX  = 4'd11,
      S_ADDI_WB  = 4'd12
   } state_t;

   localparam logic [OP_WIDTH-1:0] OP_R    = 6'b000000;
   localparam logic [OP_WIDTH-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_WIDTH-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_WIDTH-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_WIDTH-1:0] OP_J    = 6'b000010;
   localparam logic [OP_WIDTH-1:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_SE   = 2'b10;
   localparam logic [1:0] SRCB_SE2  = 2'b11;

   localparam logic [1:0] PCS_ALU  = 2'b00;
   localparam logic [1:0] PCS_OUT  = 2'b01;
   localparam logic [1:0] PCS_JUMP = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
      return (op == OP_R)   || (op == OP_LW)  || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J)   || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Output decoder: maps the current state (plus mem_ready and op)
// onto every datapath select and enable for this cycle.
module multicycle_control_decode
   import multicycle_control_pkg::*;
(
   input  state_t                state_i,
   input  logic                  mem_ready_i,
   input  logic [OP_WIDTH-1:0]   op_i,
   output ctrl_t                 ctrl_o
);

   // Moore decode; strobes that commit an access are qualified by ready
   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         S_FETCH: begin
            ctrl_o.mem_req   = 1'b1;
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCS_ALU;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_b  = SRCB_SE2;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.illegal_op = !op_legal(op_i);
            ctrl_o.instr_done = !op_legal(op_i);
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_SE;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl_o.mem_req  = 1'b1;
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.mem_req    = 1'b1;
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.iord       = 1'b1;
            ctrl_o.instr_done = mem_ready_i;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_REG;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_RTYPE_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_REG;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCS_OUT;
            ctrl_o.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_source  = PCS_JUMP;
            ctrl_o.instr_done = 1'b1;
         end
         S_ADDI_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_SE;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_ADDI_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register and next-state logic.
// Datapath controls come from multicycle_control_decode.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [OP_WIDTH-1:0] op,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic [1:0]          PCSource,
   output logic [1:0]          ALUOp,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic                RegWrite,
   output logic                RegDst,
   output logic                MemtoReg,
   output logic                instr_done,
   output logic                illegal_op,
   output logic [ST_WIDTH-1:0] state
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;

   // State register; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: memory states wait on mem_ready, op steers decode
   always_comb begin
      state_d = S_IDLE;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW,
               OP_SW:   state_d = S_MEMADR;
               OP_R:    state_d = S_EXEC;
               OP_BEQ:  state_d = S_BRANCH;
               OP_J:    state_d = S_JUMP;
               OP_ADDI: state_d = S_ADDI_EX;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:     state_d = S_RTYPE_WB;
         S_RTYPE_WB: state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_ADDI_EX:  state_d = S_ADDI_WB;
         S_ADDI_WB:  state_d = S_FETCH;
         default:    state_d = S_IDLE;
      endcase
   end

   multicycle_control_decode u_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready),
      .op_i        (op),
      .ctrl_o      (ctrl)
   );

   assign mem_req     = ctrl.mem_req;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign PCSource    = ctrl.pc_source;
   assign ALUOp       = ctrl.alu_op;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign instr_done  = ctrl.instr_done;
   assign illegal_op  = ctrl.illegal_op;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase schedules,
// per-cycle output compare, and literal latency/pulse-count checks.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
   logic       PCWriteCond, ALUSrcA, RegWrite, RegDst, MemtoReg;
   logic       instr_done, illegal_op;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic [3:0] state;

   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .instr_done(instr_done),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mreq, iord, mrd, mwr, irw, pcw, pcwc;
      logic [1:0] pcs, aop;
      logic       asa;
      logic [1:0] asb;
      logic       rw, rdst, m2r, done, ill;
      logic [3:0] st;
   } obs_t;

   typedef enum int {
      P_IDLE, P_FETCH, P_DEC, P_ILL, P_ADR, P_RD, P_LWB, P_WR,
      P_EX, P_RWB, P_BR, P_J, P_AEX, P_AWB
   } phase_t;

   obs_t   act;
   obs_t   exp_q;
   phase_t ph_q;
   bit     exp_v = 1'b0;
   int     n_tests = 0;
   int     n_fail = 0;
   int     lat = 0, last_lat = 0;
   int     n_irw = 0, n_pcw = 0, n_mw = 0, n_rw = 0;
   int     n_ill = 0, n_done = 0;

   assign act = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                 PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB,
                 RegWrite, RegDst, MemtoReg, instr_done, illegal_op,
                 state};

   // Expected outputs for one cycle of a given instruction phase
   function automatic obs_t ph(input phase_t p, input logic r);
      obs_t c = '0;
      case (p)
         P_FETCH: begin
            c.mreq = 1; c.mrd = 1; c.asb = 2'b01;
            c.irw = r; c.pcw = r; c.st = S_FETCH;
         end
         P_DEC: begin c.asb = 2'b11; c.st = S_DECODE; end
         P_ILL: begin
            c.asb = 2'b11; c.ill = 1; c.done = 1; c.st = S_DECODE;
         end
         P_ADR: begin c.asa = 1; c.asb = 2'b10; c.st = S_MEMADR; end
         P_RD: begin c.mreq = 1; c.mrd = 1; c.iord = 1; c.st = S_MEMRD; end
         P_LWB: begin c.rw = 1; c.m2r = 1; c.done = 1; c.st = S_MEMWB; end
         P_WR: begin
            c.mreq = 1; c.mwr = 1; c.iord = 1; c.done = r; c.st = S_MEMWR;
         end
         P_EX: begin c.asa = 1; c.aop = 2'b10; c.st = S_EXEC; end
         P_RWB: begin
            c.rw = 1; c.rdst = 1; c.done = 1; c.st = S_RTYPE_WB;
         end
         P_BR: begin
            c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01;
            c.done = 1; c.st = S_BRANCH;
         end
         P_J: begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; c.st = S_JUMP; end
         P_AEX: begin c.asa = 1; c.asb = 2'b10; c.st = S_ADDI_EX; end
         P_AWB: begin c.rw = 1; c.done = 1; c.st = S_ADDI_WB; end
         default: c.st = S_IDLE;
      endcase
      return c;
   endfunction

   // Per-cycle compare plus DUT-observed latency and pulse counters
   always @(negedge clk) begin
      if (exp_v) begin
         n_tests++;
         if (act !== exp_q) begin
            n_fail++;
            $display("FAIL cycle %s: act=%h exp=%h", ph_q.name(), act, exp_q);
         end
         if (state == S_IDLE) lat = 0;
         else begin
            lat++;
            if (instr_done) begin last_lat = lat; lat = 0; n_done++; end
         end
         n_irw += int'(IRWrite);
         n_pcw += int'(PCWrite);
         n_mw  += int'(MemWrite);
         n_rw  += int'(RegWrite);
         n_ill += int'(illegal_op);
      end
   end

   task automatic step(input phase_t p, input logic r, input logic rst,
                       input logic [5:0] o);
      @(posedge clk);
      #1;
      reset = rst;
      mem_ready = r;
      op = o;
      ph_q = p;
      exp_q = ph(p, r);
      exp_v = 1'b1;
   endtask

   task automatic chk(input string name, input int a, input int e);
      n_tests++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: act=%0d exp=%0d", name, a, e);
      end
   endtask

   task automatic clr();
      n_irw = 0; n_pcw = 0; n_mw = 0; n_rw = 0;
      n_ill = 0; n_done = 0; last_lat = 0;
   endtask

   // One whole instruction: wf fetch waits, wm data-access waits
   task automatic run_instr(input logic [5:0] o, input int wf, input int wm);
      clr();
      repeat (wf) step(P_FETCH, 0, 0, o);
      step(P_FETCH, 1, 0, o);
      case (o)
         6'b100011: begin
            step(P_DEC, 1, 0, o); step(P_ADR, 1, 0, o);
            repeat (wm) step(P_RD, 0, 0, o);
            step(P_RD, 1, 0, o); step(P_LWB, 1, 0, o);
         end
         6'b101011: begin
            step(P_DEC, 1, 0, o); step(P_ADR, 1, 0, o);
            repeat (wm) step(P_WR, 0, 0, o);
            step(P_WR, 1, 0, o);
         end
         6'b000000: begin
            step(P_DEC, 1, 0, o); step(P_EX, 1, 0, o); step(P_RWB, 1, 0, o);
         end
         6'b000100: begin step(P_DEC, 1, 0, o); step(P_BR, 1, 0, o); end
         6'b000010: begin step(P_DEC, 1, 0, o); step(P_J, 1, 0, o); end
         6'b001000: begin
            step(P_DEC, 1, 0, o); step(P_AEX, 1, 0, o); step(P_AWB, 1, 0, o);
         end
         default: step(P_ILL, 1, 0, o);
      endcase
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(P_IDLE, 0, 1, 6'd0);
      step(P_IDLE, 0, 0, 6'd0);

      run_instr(6'b100011, 0, 0);
      chk("lw_lat", last_lat, 5);
      chk("lw_regwrite", n_rw, 1);
      chk("lw_done", n_done, 1);

      run_instr(6'b101011, 0, 3);
      chk("sw_lat", last_lat, 7);
      chk("sw_memwrite_cycles", n_mw, 4);
      chk("sw_done", n_done, 1);

      run_instr(6'b000000, 2, 0);
      chk("r_lat", last_lat, 6);
      chk("r_irwrite_pulses", n_irw, 1);
      chk("r_pcwrite_pulses", n_pcw, 1);

      run_instr(6'b000100, 0, 0);
      chk("beq_lat", last_lat, 3);
      run_instr(6'b000010, 0, 0);
      chk("j_lat", last_lat, 3);
      chk("j_pcwrite_pulses", n_pcw, 2);
      run_instr(6'b001000, 0, 0);
      chk("addi_lat", last_lat, 4);

      run_instr(6'b111111, 0, 0);
      chk("ill_lat", last_lat, 2);
      chk("ill_pulses", n_ill, 1);
      chk("ill_regwrite", n_rw, 0);
      chk("ill_memwrite", n_mw, 0);

      run_instr(6'b100011, 1, 2);
      chk("lw_wait_lat", last_lat, 8);

      clr();
      step(P_FETCH, 1, 0, 6'b100011);
      step(P_DEC, 1, 0, 6'b100011);
      step(P_ADR, 1, 0, 6'b100011);
      step(P_RD, 0, 1, 6'b100011);
      step(P_IDLE, 0, 1, 6'b100011);
      step(P_IDLE, 0, 0, 6'b100011);
      run_instr(6'b100011, 0, 1);
      chk("post_reset_lat", last_lat, 6);
      chk("post_reset_done", n_done, 1);

      exp_v = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
